// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - keypad press-to-event front end: digit accumulation, operator latch, event pulses
// Optional KEY_SYNC_EN: 2-flop input synchronizer; a key held at reset release is ignored.
module keypad_entry #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             rec_num,
  output logic             rec_op,
  output logic             clr,
  output logic [WIDTH-1:0] operand,
  output logic [1:0]       op_code,
  output logic             is_equals,
  output logic             ovf
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [WIDTH+3:0] TEN = (WIDTH + 4)'(10);

  typedef enum logic [1:0] {EMPTY, ENTRY, AFTER_OP} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    digit_cnt, digit_cnt_n;
  logic [WIDTH-1:0] operand_n;
  logic [1:0]       op_code_n;
  logic             is_equals_n, ovf_n;
  logic             rec_num_n, rec_op_n, clr_n;
  logic             kv_in, kv_prev, key_event;
  logic [3:0]       kc_in;
  logic [WIDTH+3:0] acc;
  logic             fits;

`ifdef KEY_SYNC_EN
  logic [1:0] kv_sync;
  logic [3:0] kc_s1, kc_s2;
  logic [1:0] settle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kv_sync <= 2'b00;
      kc_s1   <= 4'd0;
      kc_s2   <= 4'd0;
      settle  <= 2'b00;
    end else begin
      kv_sync <= {kv_sync[0], key_valid};
      kc_s1   <= key_code;
      kc_s2   <= kc_s1;
      settle  <= {settle[0], 1'b1};
    end
  end

  assign kv_in = kv_sync[1];
  assign kc_in = kc_s2;

  // History holds at 1 until the synchronizer has flushed its reset zeros,
  // so a key held through reset never looks like a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         kv_prev <= 1'b1;
    else if (settle[1]) kv_prev <= kv_in;
  end
`else
  assign kv_in = key_valid;
  assign kc_in = key_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) kv_prev <= 1'b0;
    else        kv_prev <= kv_in;
  end
`endif

  assign key_event = kv_in & ~kv_prev;

  assign acc  = {4'b0000, operand} * TEN + {{WIDTH{1'b0}}, kc_in};
  assign fits = (acc[WIDTH+3:WIDTH] == 4'd0) && (digit_cnt < CW'(MAX_DIGITS));

  always_comb begin
    state_n     = state;
    digit_cnt_n = digit_cnt;
    operand_n   = operand;
    op_code_n   = op_code;
    is_equals_n = is_equals;
    ovf_n       = ovf;
    rec_num_n   = 1'b0;
    rec_op_n    = 1'b0;
    clr_n       = 1'b0;
    if (key_event) begin
      if (kc_in <= 4'd9) begin
        if (state == ENTRY) begin
          if (fits) begin
            operand_n   = acc[WIDTH-1:0];
            digit_cnt_n = digit_cnt + CW'(1);
            rec_num_n   = 1'b1;
          end else begin
            ovf_n = 1'b1;
          end
        end else begin
          operand_n   = WIDTH'(kc_in);
          digit_cnt_n = CW'(1);
          rec_num_n   = 1'b1;
          state_n     = ENTRY;
        end
      end else if (kc_in <= 4'd13) begin
        // codes 10..13 map to 0..3 by flipping bit 1 of the low pair
        op_code_n   = kc_in[1:0] ^ 2'b10;
        is_equals_n = 1'b0;
        ovf_n       = 1'b0;
        digit_cnt_n = '0;
        rec_op_n    = 1'b1;
        state_n     = AFTER_OP;
      end else if (kc_in == 4'd14) begin
        is_equals_n = 1'b1;
        ovf_n       = 1'b0;
        digit_cnt_n = '0;
        rec_op_n    = 1'b1;
        state_n     = AFTER_OP;
      end else begin
        operand_n   = '0;
        op_code_n   = 2'd0;
        is_equals_n = 1'b0;
        ovf_n       = 1'b0;
        digit_cnt_n = '0;
        clr_n       = 1'b1;
        state_n     = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      digit_cnt <= '0;
      operand   <= '0;
      op_code   <= 2'd0;
      is_equals <= 1'b0;
      ovf       <= 1'b0;
      rec_num   <= 1'b0;
      rec_op    <= 1'b0;
      clr       <= 1'b0;
    end else begin
      state     <= state_n;
      digit_cnt <= digit_cnt_n;
      operand   <= operand_n;
      op_code   <= op_code_n;
      is_equals <= is_equals_n;
      ovf       <= ovf_n;
      rec_num   <= rec_num_n;
      rec_op    <= rec_op_n;
      clr       <= clr_n;
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - scoreboard bench for keypad_entry (16-bit/4-digit and 8-bit/3-digit instances)
module tb_keypad_entry;

  localparam logic [2:0] K_NUM = 3'b001, K_OP = 3'b010, K_CLR = 3'b100;

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] opd;
    logic [1:0]  op;
    logic        eq;
  } exp_t;

  logic        clk, rst_n;
  logic        kv, kv8;
  logic [3:0]  kc, kc8;
  logic        rec_num, rec_op, clr, is_equals, ovf;
  logic [15:0] operand;
  logic [1:0]  op_code;
  logic        rec_num8, rec_op8, clr8, is_equals8, ovf8;
  logic [7:0]  operand8;
  logic [1:0]  op_code8;

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t q8[$];
  exp_t e, e8;
  logic prev_any = 1'b0;
  logic prev_any8 = 1'b0;

  keypad_entry #(.WIDTH(16), .MAX_DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(kv), .key_code(kc),
    .rec_num(rec_num), .rec_op(rec_op), .clr(clr), .operand(operand),
    .op_code(op_code), .is_equals(is_equals), .ovf(ovf)
  );

  keypad_entry #(.WIDTH(8), .MAX_DIGITS(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .key_valid(kv8), .key_code(kc8),
    .rec_num(rec_num8), .rec_op(rec_op8), .clr(clr8), .operand(operand8),
    .op_code(op_code8), .is_equals(is_equals8), .ovf(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic [2:0] kind, input int opd, input int op, input bit eq);
    q.push_back('{kind, 16'(opd), 2'(op), eq});
  endtask

  task automatic add8(input logic [2:0] kind, input int opd, input int op, input bit eq);
    q8.push_back('{kind, 16'(opd), 2'(op), eq});
  endtask

  task automatic press(input bit sel, input logic [3:0] code, input int hold, input int gap);
    if (sel) begin kv8 = 1'b1; kc8 = code; end
    else     begin kv  = 1'b1; kc  = code; end
    repeat (hold) @(negedge clk);
    kv  = 1'b0;
    kv8 = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && (rec_num | rec_op | clr)) begin
      check("pulse_gap", 32'(prev_any), 32'd0);
      if (q.size() == 0) begin
        check("unexpected_pulse", 32'({clr, rec_op, rec_num}), 32'd0);
      end else begin
        e = q.pop_front();
        check("pulse_kind", 32'({clr, rec_op, rec_num}), 32'(e.kind));
        check("operand",    32'(operand),   32'(e.opd));
        check("op_code",    32'(op_code),   32'(e.op));
        check("is_equals",  32'(is_equals), 32'(e.eq));
      end
    end
    prev_any = rec_num | rec_op | clr;
  end

  always @(negedge clk) begin
    if (rst_n && (rec_num8 | rec_op8 | clr8)) begin
      if (q8.size() == 0) begin
        check("unexpected_pulse8", 32'({clr8, rec_op8, rec_num8}), 32'd0);
      end else begin
        e8 = q8.pop_front();
        check("pulse_kind8", 32'({clr8, rec_op8, rec_num8}), 32'(e8.kind));
        check("operand8",    32'(operand8), 32'(e8.opd));
      end
    end
    prev_any8 = rec_num8 | rec_op8 | clr8;
  end

  initial begin
    rst_n = 1'b0;
    kv = 1'b0; kc = 4'd0; kv8 = 1'b0; kc8 = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_operand",   32'(operand),   32'd0);
    check("rst_op_code",   32'(op_code),   32'd0);
    check("rst_is_equals", 32'(is_equals), 32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    check("rst_pulses",    32'({clr, rec_op, rec_num}), 32'd0);
    check("rst_operand8",  32'(operand8),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1, 2, 3, add
    add(K_NUM, 1, 0, 0);   press(0, 4'd1, 5, 2);
    add(K_NUM, 12, 0, 0);  press(0, 4'd2, 5, 2);
    add(K_NUM, 123, 0, 0); press(0, 4'd3, 5, 2);
    add(K_OP, 123, 0, 0);  press(0, 4'd10, 5, 2);
    check("drain_add", 32'(q.size()), 32'd0);

    // 4, equals
    add(K_NUM, 4, 0, 0);   press(0, 4'd4, 5, 2);
    add(K_OP, 4, 0, 1);    press(0, 4'd14, 5, 2);

    // 6,5,5,3 then a fifth digit hits the limit; is_equals still held
    add(K_NUM, 6, 0, 1);    press(0, 4'd6, 5, 2);
    add(K_NUM, 65, 0, 1);   press(0, 4'd5, 5, 2);
    add(K_NUM, 655, 0, 1);  press(0, 4'd5, 5, 2);
    add(K_NUM, 6553, 0, 1); press(0, 4'd3, 5, 2);
    press(0, 4'd5, 5, 2);
    check("limit_ovf",     32'(ovf),     32'd1);
    check("limit_operand", 32'(operand), 32'd6553);
    add(K_OP, 6553, 2, 0);  press(0, 4'd12, 5, 2);
    check("mul_ovf_clear", 32'(ovf), 32'd0);

    // long hold, then clear
    add(K_NUM, 7, 2, 0);   press(0, 4'd7, 20, 2);
    add(K_CLR, 0, 0, 0);   press(0, 4'd15, 5, 2);
    check("drain_hold", 32'(q.size()), 32'd0);

    // back-to-back presses with a single low cycle between
    add(K_NUM, 1, 0, 0);   press(0, 4'd1, 1, 1);
    add(K_NUM, 12, 0, 0);  press(0, 4'd2, 1, 2);
    add(K_CLR, 0, 0, 0);   press(0, 4'd15, 2, 2);

    // operator from EMPTY, then 42
    add(K_OP, 0, 1, 0);    press(0, 4'd11, 3, 2);
    add(K_NUM, 4, 1, 0);   press(0, 4'd4, 3, 2);
    add(K_NUM, 42, 1, 0);  press(0, 4'd2, 3, 2);
    check("pre_reset_operand", 32'(operand), 32'd42);
    check("drain_pre_reset",   32'(q.size()), 32'd0);

    // async reset while a key is held, release with key still held
    kv = 1'b1; kc = 4'd5;
    #2 rst_n = 1'b0;
    #1;
    check("async_operand", 32'(operand), 32'd0);
    check("async_op_code", 32'(op_code), 32'd0);
    check("async_pulses",  32'({clr, rec_op, rec_num}), 32'd0);
    @(negedge clk);
`ifndef KEY_SYNC_EN
    add(K_NUM, 5, 0, 0);
`endif
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    kv = 1'b0;
    repeat (6) @(negedge clk);
    check("drain_reset_press", 32'(q.size()), 32'd0);

    // narrow instance: 2, 5, 6 -> 256 does not fit in 8 bits
    add8(K_NUM, 2, 0, 0);  press(1, 4'd2, 5, 2);
    add8(K_NUM, 25, 0, 0); press(1, 4'd5, 5, 2);
    press(1, 4'd6, 5, 2);
    check("w8_ovf",     32'(ovf8),     32'd1);
    check("w8_operand", 32'(operand8), 32'd25);
    check("w8_drain",   32'(q8.size()), 32'd0);
    check("final_drain", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
